// File: rtl/pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl
//
// Sequencing controller for the PLL: generates the PLL reset pulse, waits
// for lock with a timeout and bounded retries, qualifies lock stability, and
// then raises a ready flag that releases logic in the PLL output domain.
// Runs entirely on the PLL reference clock.
//
// Ports:
//   clkin        in   reference clock, sole clock of the block
//   reset_p      in   asynchronous active-high reset
//   pll_lock     in   PLL lock (asynchronous, synchronized internally)
//   restart      in   single-cycle pulse, restarts the reset sequence
//   pll_reset_p  out  PLL reset (registered)
//   pll_ready    out  PLL qualified locked (registered)
//   fail         out  sticky, set after MAX_RETRY failed attempts
//   retry_cnt    out  consecutive failed lock attempts
//   lost_cnt     out  saturating count of lock losses seen in RUN
//   state        out  FSM state, for debug
// -----------------------------------------------------------------------------
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic       clkin,
    input  logic       reset_p,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset_p,
    output logic       pll_ready,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] lost_cnt,
    output logic [2:0] state
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [8:0]    RETRY_LIMIT = 9'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    retry_q, retry_d;
    logic [7:0]    lost_q, lost_d;
    logic          fail_q, fail_d;
    logic          pll_reset_q, pll_reset_d;
    logic          ready_q, ready_d;
    logic          lock_meta_q, lock_s_q;
    logic [8:0]    retry_inc;

    assign retry_inc = {1'b0, retry_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        lost_d  = lost_q;
        fail_d  = fail_q;

        if (restart) begin
            // Restart wins over everything; lost_cnt is deliberately kept.
            state_d = ST_RESET;
            cnt_d   = '0;
            retry_d = 8'd0;
            fail_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is checked before the timeout so a lock arriving
                    // on the last allowed cycle still counts.
                    if (lock_s_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        retry_d = retry_inc[7:0];
                        cnt_d   = '0;
                        if (retry_inc >= RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = ST_RESET;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_s_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = 8'd0;
                    end
                end
                ST_RUN: begin
                    // Counter is parked in RUN and FAIL so it can never wrap.
                    cnt_d = '0;
                    if (!lock_s_q) begin
                        state_d = ST_RESET;
                        lost_d  = (lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
                    end
                end
                ST_FAIL: begin
                    cnt_d  = '0;
                    fail_d = 1'b1;
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they change on the same
        // edge as the state and come straight from flops.
        pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clkin or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            lost_q      <= 8'd0;
            fail_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            fail_q      <= fail_d;
            pll_reset_q <= pll_reset_d;
            ready_q     <= ready_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign pll_reset_p = pll_reset_q;
    assign pll_ready   = ready_q;
    assign fail        = fail_q;
    assign retry_cnt   = retry_q;
    assign lost_cnt    = lost_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_ctrl
//
// Directed sequence with randomized lock delays, hold times and glitch
// positions. Expected values come from timing rules: reset pulse length,
// wait-lock window length, lock-to-ready latency, loss latency, and
// counters tracked as plain integers.
// -----------------------------------------------------------------------------
module tb_pll_lock_ctrl;
    localparam int RST_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 300;
    localparam int STABLE_CYCLES = 64;
    localparam int MAX_RETRY     = 3;

    logic       clkin = 1'b0;
    logic       reset_p = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_reset_p, pll_ready, fail;
    logic [7:0] retry_cnt, lost_cnt;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int exp_lost = 0;
    int rise_edge;

    pll_lock_ctrl #(
        .RST_CYCLES(RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clkin(clkin),
        .reset_p(reset_p),
        .pll_lock(pll_lock),
        .restart(restart),
        .pll_reset_p(pll_reset_p),
        .pll_ready(pll_ready),
        .fail(fail),
        .retry_cnt(retry_cnt),
        .lost_cnt(lost_cnt),
        .state(state)
    );

    // clock and edge counter
    always #5 clkin = ~clkin;
    always @(posedge clkin) ncyc <= ncyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts negedges with pll_reset_p high, starting at the current one.
    task automatic measure_reset_high(input string tag);
        int n = 0;
        while (pll_reset_p === 1'b1 && n < RST_CYCLES + 40) begin
            n++;
            @(negedge clkin);
        end
        check(tag, n, RST_CYCLES);
    endtask

    // Counts negedges with pll_reset_p low while lock is held off.
    task automatic measure_wait_window(input string tag);
        int n = 0;
        while (pll_reset_p === 1'b0 && n < LOCK_TIMEOUT + 40) begin
            n++;
            @(negedge clkin);
        end
        check(tag, n, LOCK_TIMEOUT + 1);
    endtask

    // Raise lock so it is first sampled d edges after the reset fall edge.
    task automatic lock_after(input int d, output int re);
        repeat (d - 1) @(negedge clkin);
        pll_lock = 1'b1;
        re = ncyc + 1;
    endtask

    task automatic expect_ready(input string tag, input int re);
        while (pll_ready !== 1'b1 && ncyc < re + STABLE_CYCLES + 40) @(negedge clkin);
        check({tag, "_lat"}, ncyc - re, 2 + STABLE_CYCLES);
        check({tag, "_rstp"}, pll_reset_p, 0);
        check({tag, "_state"}, state, 3);
    endtask

    task automatic lose_lock(input string tag);
        int fe;
        pll_lock = 1'b0;
        fe = ncyc + 1;
        while (pll_ready !== 1'b0 && ncyc < fe + 20) @(negedge clkin);
        exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
        check({tag, "_lat"}, ncyc - fe, 2);
        check({tag, "_rstp"}, pll_reset_p, 1);
        check({tag, "_state"}, state, 0);
        check({tag, "_lost"}, lost_cnt, exp_lost);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clkin);
        restart = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clkin);
        check("rst_pll_reset_p", pll_reset_p, 1);
        check("rst_ready", pll_ready, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_lost", lost_cnt, 0);
        check("rst_state", state, 0);

        // power-up lock, lock 100 cycles after reset fall
        reset_p = 1'b0;
        measure_reset_high("pwr_rst_len");
        check("pwr_wait_state", state, 1);
        lock_after(100, rise_edge);
        expect_ready("pwr_ready", rise_edge);
        check("pwr_retry", retry_cnt, 0);
        check("pwr_fail", fail, 0);

        // repeated lock loss in RUN, lost_cnt saturates
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge clkin);
            lose_lock("loss");
            measure_reset_high("loss_rst_len");
            lock_after($urandom_range(1, 20), rise_edge);
            expect_ready("loss_ready", rise_edge);
        end
        check("loss_sat", lost_cnt, 255);

        // unstable lock during STABLE
        for (int i = 0; i < 3; i++) begin
            int c;
            int g;
            lose_lock("unst_loss");
            measure_reset_high("unst_rst_len");
            lock_after($urandom_range(1, 40), rise_edge);
            c = $urandom_range(1, STABLE_CYCLES - 4);
            g = $urandom_range(3, 6);
            while (ncyc < rise_edge + 2 + c) @(negedge clkin);
            pll_lock = 1'b0;
            repeat (3) @(negedge clkin);
            check("unst_state", state, 1);
            check("unst_retry", retry_cnt, 0);
            check("unst_ready", pll_ready, 0);
            repeat (g - 3) @(negedge clkin);
            pll_lock = 1'b1;
            rise_edge = ncyc + 1;
            expect_ready("unst_ready_after", rise_edge);
        end

        // restart from RUN, then one timeout, then lock
        pll_lock = 1'b0;
        pulse_restart();
        check("rsrun_state", state, 0);
        check("rsrun_rstp", pll_reset_p, 1);
        check("rsrun_ready", pll_ready, 0);
        check("rsrun_lost", lost_cnt, exp_lost);
        measure_reset_high("rsrun_rst_len");
        measure_wait_window("to1_window");
        check("to1_retry", retry_cnt, 1);
        check("to1_state", state, 0);
        measure_reset_high("to1_rst_len");
        lock_after($urandom_range(1, 100), rise_edge);
        expect_ready("to1_ready", rise_edge);
        check("to1_retry_clr", retry_cnt, 0);

        // timeouts until FAIL
        lose_lock("tof_loss");
        for (int a = 1; a <= MAX_RETRY; a++) begin
            measure_reset_high("tof_rst_len");
            measure_wait_window("tof_window");
            check("tof_retry", retry_cnt, a);
            check("tof_state", state, (a < MAX_RETRY) ? 0 : 4);
            check("tof_fail", fail, (a < MAX_RETRY) ? 0 : 1);
        end
        repeat (50) @(negedge clkin);
        check("fail_hold_state", state, 4);
        check("fail_hold_rstp", pll_reset_p, 1);
        check("fail_hold_ready", pll_ready, 0);
        check("fail_hold_fail", fail, 1);

        // restart from FAIL, then restart inside RESET extends the pulse
        pulse_restart();
        check("rsf_state", state, 0);
        check("rsf_fail", fail, 0);
        check("rsf_retry", retry_cnt, 0);
        check("rsf_lost", lost_cnt, exp_lost);
        repeat ($urandom_range(3, 10)) @(negedge clkin);
        pulse_restart();
        measure_reset_high("rsf_ext_len");
        lock_after($urandom_range(1, 100), rise_edge);
        expect_ready("rsf_ready", rise_edge);

        // asynchronous reset mid-RUN
        repeat ($urandom_range(1, 20)) @(negedge clkin);
        #2;
        reset_p = 1'b1;
        pll_lock = 1'b0;
        #1;
        check("arst_rstp", pll_reset_p, 1);
        check("arst_ready", pll_ready, 0);
        @(negedge clkin);
        reset_p = 1'b0;
        exp_lost = 0;
        check("arst_state", state, 0);
        check("arst_lost", lost_cnt, 0);
        check("arst_retry", retry_cnt, 0);
        check("arst_fail", fail, 0);
        measure_reset_high("arst_rst_len");
        lock_after($urandom_range(1, 100), rise_edge);
        expect_ready("arst_ready_after", rise_edge);
        check("arst_lost_end", lost_cnt, exp_lost);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
